uart_loader: RTL and testbench

Serial boot loader sitting directly upstream of the RV32I core on the DE10-Lite. It receives a framed program image on `ser_rx`, assembles little-endian 32-bit words, and writes them sequentially into the core's word-indexed instruction/data memory. The core is held stopped until the frame checksum verifies; then `cpu_run` releases it to fetch from word 0 (`PC = 0x8000_0000`).

---
 rtl/uart_loader.sv | 216 +++++++++++++++++++++
 tb/tb_uart_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// uart_loader: serial boot loader. Receives an 8N1 framed image, assembles
// little-endian words, writes them to core memory, and releases the core
// once the XOR checksum of the payload matches.
module uart_loader #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 2056,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ser_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              err,
  output logic [15:0]       byte_cnt
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
  localparam logic [31:0]   DEPTH_V = 32'(DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [2:0] {F_SYNC, F_LEN0, F_LEN1, F_DATA, F_CSUM, F_DONE} fr_t;

  // ---------------- RX front end ----------------
  rx_t           rx_st, rx_nx;
  logic          s1, s2, s3;
  logic          fall;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_valid, rx_ferr;
  logic [7:0]    rx_byte;
  logic          tick_half, tick_full;

  assign fall      = s3 & ~s2;
  assign tick_half = (cnt == HALF_M1);
  assign tick_full = (cnt == FULL_M1);
  assign rx_byte   = shreg;

  // Receiver state register
  always_ff @(posedge clk) begin
    if (!reset) rx_st <= RX_IDLE;
    else        rx_st <= rx_nx;
  end

  // Receiver next state: half-period start check, 8 data bits, stop bit
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      RX_IDLE:  if (fall) rx_nx = RX_START;
      RX_START: if (tick_half) rx_nx = s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_idx == 3'd7) rx_nx = RX_STOP;
      RX_STOP:  if (tick_full) rx_nx = RX_IDLE;
      default:  rx_nx = RX_IDLE;
    endcase
  end

  // Synchronizer, bit timer, shift register and byte/framing-error pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      s3       <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      s1       <= ser_rx;
      s2       <= s1;
      s3       <= s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      cnt      <= cnt + 1'b1;
      case (rx_st)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
        end
        RX_START: if (tick_half) cnt <= '0;
        RX_DATA: if (tick_full) begin
          cnt     <= '0;
          shreg   <= {s2, shreg[7:1]};
          bit_idx <= bit_idx + 1'b1;
        end
        RX_STOP: if (tick_full) begin
          cnt      <= '0;
          rx_valid <= s2;
          rx_ferr  <= ~s2;
        end
        default: cnt <= '0;
      endcase
    end
  end

  // ---------------- Frame FSM ----------------
  fr_t         f_st, f_nx;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] n_cand;
  logic [7:0]  csum;
  logic [23:0] wbuf;
  logic        last_byte;
  logic        do_clr, do_lo, do_hi, do_data, do_err, do_run;

  assign n_cand    = {rx_byte, len_lo};
  assign last_byte = ({2'b00, byte_cnt} + 18'd1) == {len, 2'b00};

  // Frame state register
  always_ff @(posedge clk) begin
    if (!reset) f_st <= F_SYNC;
    else        f_st <= f_nx;
  end

  // Frame next state and datapath controls; only rx pulses move it
  always_comb begin
    f_nx    = f_st;
    do_clr  = 1'b0;
    do_lo   = 1'b0;
    do_hi   = 1'b0;
    do_data = 1'b0;
    do_err  = 1'b0;
    do_run  = 1'b0;
    if (rx_ferr && f_st != F_DONE) begin
      do_err = 1'b1;
      f_nx   = F_SYNC;
    end else if (rx_valid) begin
      case (f_st)
        F_SYNC: if (rx_byte == 8'hA5) begin
          do_clr = 1'b1;
          f_nx   = F_LEN0;
        end
        F_LEN0: begin
          do_lo = 1'b1;
          f_nx  = F_LEN1;
        end
        F_LEN1: begin
          do_hi = 1'b1;
          if (n_cand == 16'd0)                 f_nx = F_CSUM;
          else if ({16'd0, n_cand} > DEPTH_V) begin
            do_err = 1'b1;
            f_nx   = F_SYNC;
          end else                             f_nx = F_DATA;
        end
        F_DATA: begin
          do_data = 1'b1;
          if (last_byte) f_nx = F_CSUM;
        end
        F_CSUM: begin
          if (rx_byte == csum) begin
            do_run = 1'b1;
            f_nx   = F_DONE;
          end else begin
            do_err = 1'b1;
            f_nx   = F_SYNC;
          end
        end
        F_DONE:  f_nx = F_DONE;
        default: f_nx = F_SYNC;
      endcase
    end
  end

  // Word assembly, write strobe, address advance and status flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      err       <= 1'b0;
      byte_cnt  <= '0;
      len_lo    <= '0;
      len       <= '0;
      csum      <= '0;
      wbuf      <= '0;
    end else begin
      mem_we <= 1'b0;
      // address moves on the cycle after the strobe so it is stable during it
      if (mem_we) mem_addr <= mem_addr + 1'b1;
      if (do_clr) begin
        err      <= 1'b0;
        byte_cnt <= '0;
        csum     <= '0;
        mem_addr <= '0;
      end
      if (do_lo) len_lo <= rx_byte;
      if (do_hi) len    <= n_cand;
      if (do_data) begin
        csum     <= csum ^ rx_byte;
        byte_cnt <= byte_cnt + 16'd1;
        case (byte_cnt[1:0])
          2'd0: wbuf[7:0]   <= rx_byte;
          2'd1: wbuf[15:8]  <= rx_byte;
          2'd2: wbuf[23:16] <= rx_byte;
          default: begin
            mem_wdata <= {rx_byte, wbuf};
            mem_we    <= 1'b1;
          end
        endcase
      end
      if (do_err) err     <= 1'b1;
      if (do_run) cpu_run <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: frames driven bit-serially, expected writes queued
// as frames are built and checked by a monitor as mem_we strobes appear.
module tb_uart_loader;
  localparam int CLK_HZ = 160;
  localparam int BAUD   = 10;
  localparam int DIV    = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ser_rx = 1'b1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_run;
  logic              err;
  logic [15:0]       byte_cnt;

  uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .ser_rx(ser_rx), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .err(err), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          nwr = 0;
  logic        prev_we = 1'b0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [7:0]  txq[$];
  logic [31:0] img[0:15];

  // Monitor: every strobe must match the next queued write and last one cycle
  always @(negedge clk) begin
    if (reset && mem_we) begin
      nwr++;
      vectors++;
      if (prev_we) begin
        miscompares++;
        $display("FAIL we_width: mem_we high on consecutive cycles, required 1 cycle");
      end
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== mon_e) begin
          miscompares++;
          $display("FAIL write: addr=%0d data=%h, required addr=%0d data=%h",
                   mem_addr, mem_wdata, mon_e.a, mon_e.d);
        end
      end
    end
    prev_we = mem_we;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    ser_rx = 1'b0;
    cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      cyc(DIV);
    end
    ser_rx = stop;
    cyc(DIV);
    ser_rx = 1'b1;
  endtask

  task automatic send_txq();
    while (txq.size() != 0) send_byte(txq.pop_front(), 1'b1);
    cyc(4);
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    ser_rx = 1'b1;
    cyc(3);
    reset = 1'b1;
    cyc(2);
  endtask

  // Build sync/length/payload/checksum into txq; optionally queue the writes
  task automatic build(input int n, input logic bad, input logic expw);
    logic [7:0] cs;
    logic [7:0] b;
    wr_t        e;
    cs = 8'h00;
    txq.delete();
    txq.push_back(8'hA5);
    txq.push_back(n[7:0]);
    txq.push_back(n[15:8]);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[w][8*k +: 8];
        txq.push_back(b);
        cs = cs ^ b;
      end
      if (expw) begin
        e.a = ADDR_W'(w);
        e.d = img[w];
        exp_q.push_back(e);
      end
    end
    txq.push_back(cs ^ {7'd0, bad});
  endtask

  task automatic test_reset();
    int w0;
    reset  = 1'b0;
    ser_rx = 1'b1;
    cyc(3);
    vectors++;
    if ({mem_we, mem_addr, mem_wdata, cpu_run, err, byte_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: we=%b addr=%0d wdata=%h run=%b err=%b cnt=%0d, required all 0",
               mem_we, mem_addr, mem_wdata, cpu_run, err, byte_cnt);
    end
    reset = 1'b1;
    w0 = nwr;
    cyc(1000);
    vectors++;
    if (nwr != w0 || {cpu_run, err} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle: writes=%0d run=%b err=%b, required 0 writes run=0 err=0",
               nwr - w0, cpu_run, err);
    end
  endtask

  task automatic test_good_frame();
    int w0;
    do_reset();
    img[0] = 32'h00100513;
    img[1] = 32'h80000093;
    w0 = nwr;
    build(2, 1'b0, 1'b1);
    send_txq();
    vectors++;
    if (nwr - w0 != 2 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL good_writes: writes=%0d pending=%0d, required 2 and 0", nwr - w0, exp_q.size());
    end
    vectors++;
    if ({cpu_run, err, byte_cnt, mem_addr} !== {1'b1, 1'b0, 16'd8, ADDR_W'(2)}) begin
      miscompares++;
      $display("FAIL good_status: run=%b err=%b cnt=%0d addr=%0d, required run=1 err=0 cnt=8 addr=2",
               cpu_run, err, byte_cnt, mem_addr);
    end
  endtask

  task automatic test_bad_csum();
    int w0;
    do_reset();
    w0 = nwr;
    build(2, 1'b1, 1'b1);
    send_txq();
    vectors++;
    if (nwr - w0 != 2 || {err, cpu_run} !== 2'b10) begin
      miscompares++;
      $display("FAIL bad_csum: writes=%0d err=%b run=%b, required 2 writes err=1 run=0",
               nwr - w0, err, cpu_run);
    end
    build(2, 1'b0, 1'b1);
    send_txq();
    vectors++;
    if ({err, cpu_run} !== 2'b01) begin
      miscompares++;
      $display("FAIL csum_recover: err=%b run=%b, required err=0 run=1", err, cpu_run);
    end
  endtask

  task automatic test_len_empty();
    int w0;
    do_reset();
    w0 = nwr;
    txq = '{8'hA5, 8'h09, 8'h00};
    send_txq();
    vectors++;
    if (nwr != w0 || {err, cpu_run} !== 2'b10) begin
      miscompares++;
      $display("FAIL len_too_big: writes=%0d err=%b run=%b, required 0 writes err=1 run=0",
               nwr - w0, err, cpu_run);
    end
    txq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_txq();
    vectors++;
    if (nwr != w0 || {err, cpu_run, byte_cnt} !== {1'b0, 1'b1, 16'd0}) begin
      miscompares++;
      $display("FAIL empty_frame: writes=%0d err=%b run=%b cnt=%0d, required 0 writes err=0 run=1 cnt=0",
               nwr - w0, err, cpu_run, byte_cnt);
    end
    // full-depth frame: address ends at DEPTH
    do_reset();
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom();
    w0 = nwr;
    build(DEPTH, 1'b0, 1'b1);
    send_txq();
    vectors++;
    if (nwr - w0 != DEPTH || {cpu_run, err, byte_cnt, mem_addr} !== {1'b1, 1'b0, 16'd32, ADDR_W'(DEPTH)}) begin
      miscompares++;
      $display("FAIL full_depth: writes=%0d run=%b err=%b cnt=%0d addr=%0d, required 8 writes run=1 err=0 cnt=32 addr=8",
               nwr - w0, cpu_run, err, byte_cnt, mem_addr);
    end
  endtask

  task automatic test_line_errors();
    int w0;
    do_reset();
    img[0] = 32'h00100513;
    img[1] = 32'h80000093;
    ser_rx = 1'b0;
    cyc(5);
    ser_rx = 1'b1;
    cyc(DIV);
    vectors++;
    if ({err, byte_cnt} !== 17'd0) begin
      miscompares++;
      $display("FAIL glitch: err=%b cnt=%0d, required err=0 cnt=0", err, byte_cnt);
    end
    // receiver must be idle again, so an immediate frame loads
    build(2, 1'b0, 1'b1);
    send_txq();
    vectors++;
    if ({err, cpu_run} !== 2'b01) begin
      miscompares++;
      $display("FAIL glitch_then_frame: err=%b run=%b, required err=0 run=1", err, cpu_run);
    end
    do_reset();
    w0 = nwr;
    txq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05};
    send_txq();
    send_byte(8'h10, 1'b0);
    cyc(DIV);
    vectors++;
    if (nwr != w0 || {err, cpu_run, byte_cnt} !== {1'b1, 1'b0, 16'd2}) begin
      miscompares++;
      $display("FAIL framing: writes=%0d err=%b run=%b cnt=%0d, required 0 writes err=1 run=0 cnt=2",
               nwr - w0, err, cpu_run, byte_cnt);
    end
    build(2, 1'b0, 1'b1);
    send_txq();
    vectors++;
    if (nwr - w0 != 2 || {err, cpu_run} !== 2'b01) begin
      miscompares++;
      $display("FAIL framing_resync: writes=%0d err=%b run=%b, required 2 writes err=0 run=1",
               nwr - w0, err, cpu_run);
    end
  endtask

  task automatic test_terminal_reset();
    int w0;
    w0 = nwr;
    img[0] = 32'hDEADBEEF;
    build(1, 1'b0, 1'b0);
    send_txq();
    vectors++;
    if (nwr != w0 || cpu_run !== 1'b1) begin
      miscompares++;
      $display("FAIL terminal: writes=%0d run=%b, required 0 writes run=1", nwr - w0, cpu_run);
    end
    ser_rx = 1'b0;
    cyc(3 * DIV);
    reset = 1'b0;
    cyc(1);
    vectors++;
    if ({cpu_run, err, byte_cnt, mem_addr} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: run=%b err=%b cnt=%0d addr=%0d, required all 0",
               cpu_run, err, byte_cnt, mem_addr);
    end
    ser_rx = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc(2 * DIV);
    img[0] = 32'h12345678;
    img[1] = 32'hCAFEF00D;
    w0 = nwr;
    build(2, 1'b0, 1'b1);
    send_txq();
    vectors++;
    if (nwr - w0 != 2 || exp_q.size() != 0 || {cpu_run, err} !== 2'b10) begin
      miscompares++;
      $display("FAIL reload: writes=%0d pending=%0d run=%b err=%b, required 2 writes 0 pending run=1 err=0",
               nwr - w0, exp_q.size(), cpu_run, err);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_empty();
    test_line_errors();
    test_terminal_reset();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: %0d expected writes never seen, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
